riscv_v_lmul_sequencer: RTL
===========================

Name: riscv_v_lmul_sequencer

Overview:
Splits one decoded vector instruction with register grouping (LMUL > 1) into single-register micro-ops of 128 bits each, one per cycle, for riscv_v_execute.
Sits between decode/issue and the execute stage. It generates per-micro-op register addresses and element-relative vl/vstart. Stall is handled with a valid/ready handshake toward execute.

Parameters:
VLEN, 128, vector register width in bits (RISCV_V_VLEN)
NUM_BYTES, VLEN/8, max elements per register (SEW=8)
MAX_LMUL, 8, max register group size
VL_W, $clog2(NUM_BYTES*MAX_LMUL)+1 = 8, width of vl/vstart (holds 0..128)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
in_valid  in  1  instruction offered
in_ready  out  1  sequencer accepts instruction
in_vtype  in  9  [8]=vill, [7]=vma, [6]=vta, [5:3]=vsew, [2:0]=vlmul
in_vl  in  VL_W  vector length
in_vstart  in  VL_W  start element
in_vs1  in  5  srca base register
in_vs2  in  5  srcb base register
in_vd  in  5  destination base register
in_is_reduct  in  1  reduction: vs1/vd not stepped
flush  in  1  kill in-flight sequence
uop_valid  out  1  micro-op valid
uop_ready  in  1  execute accepts micro-op
uop_vs1, uop_vs2, uop_vd  out  5 each  per-uop register addresses
uop_vl  out  VL_W  elements active in this register (0..EPR)
uop_vstart  out  VL_W  first active element in this register
uop_first, uop_last  out  1 each  group boundary flags
done  out  1  one-cycle pulse: instruction fully issued
illegal  out  1  one-cycle pulse: instruction rejected

Behaviour:
- Reset (rst=0, asynchronous) sets state to IDLE. in_ready=1. All uop_* outputs, done and illegal are 0.
- States are IDLE and ISSUE. in_ready = (state==IDLE). An instruction is accepted when in_valid & in_ready.
- Elements per register: EPR = NUM_BYTES >> vsew, with vsew 0..4 giving 16, 8, 4, 2, 1.
- Group size: NREG = 1<<vlmul for vlmul 0..3. Fractional vlmul (5..7) gives NREG=1. vlmul=4 is reserved.
- Illegal on accept, checked in this order:
  - vill=1
  - vsew>4
  - vlmul=4
  - vs1, vs2 or vd not a multiple of NREG (vs1/vd exempt when in_is_reduct)
  - Response: illegal pulses in the next cycle, no micro-ops are issued, state stays IDLE.
- Empty instruction (vl==0 or vstart>=vl): done pulses in the next cycle, no micro-ops, state stays IDLE.
- Otherwise the instruction is latched and state goes to ISSUE:
  - first = vstart/EPR
  - last = min(NREG, ceil(vl/EPR)) - 1
  - index i runs from first to last
- Micro-op i (registered outputs, first micro-op valid the cycle after accept):
  - uop_vs2 = vs2+i
  - uop_vs1 = vs1+i and uop_vd = vd+i; both held at base when in_is_reduct
  - uop_vstart = clamp(vstart - i*EPR, 0, EPR)
  - uop_vl = clamp(vl - i*EPR, 0, EPR)
  - uop_first = (i==first); uop_last = (i==last)
- Handshake toward execute:
  - uop_valid holds with all uop_* stable until uop_ready.
  - On a transfer, i increments and the next micro-op is presented the following cycle.
  - Throughput is one micro-op per cycle while uop_ready=1.
- When the uop_last transfer occurs:
  - done pulses in the same cycle.
  - State returns to IDLE, and in_ready=1 in the next cycle.
- flush:
  - Has priority over everything. In the next cycle: state=IDLE, uop_valid=0, no done.
  - A flush coincident with an accept discards the new instruction.
- Register addresses never wrap past 31 for legal (aligned) groups.
- Asynchronous reset mid-sequence abandons the sequence with no done.

Decomposition:
- riscv_v_pkg:
  - vtype field offsets and a vtype struct
  - RISCV_V_MAX_LMUL, RISCV_V_NUM_ELEMENTS_REG
  - an LMUL decode enum (LMUL_1, LMUL_2, LMUL_4, LMUL_8, LMUL_RSVD, LMUL_F8, LMUL_F4, LMUL_F2)
  - the sequencer state enum
- One combinational sub-module, riscv_v_uop_bounds: takes vl, vstart, EPR and i, and returns uop_vl, uop_vstart, first and last. It is shared with later load/store sequencing.

Test Plan:
- vsew=0, vlmul=2 (LMUL4), vl=64, vstart=0, vs2=8, vs1=4, vd=12, uop_ready=1 -> 4 micro-ops:
  - vs2 = 8,9,10,11; vs1 = 4..7; vd = 12..15
  - uop_vl = 16 each
  - first/last on micro-ops 0 and 3
  - done on the 4th transfer
- vsew=2, vlmul=3 (LMUL8), vl=10, vstart=5, vs2=16 -> micro-ops for i=1,2 only:
  - i=1: uop_vstart = 1, 0; uop_vl = 4 and 2 across the two micro-ops
  - vs2 = 17, 18
- Same as the first scenario with uop_ready low 3 cycles at micro-op 1 -> outputs stable throughout the stall, 4 micro-ops in total, in_ready=0 until after done.
- vlmul=1 with vs2=3 (misaligned), then vill=1, then vl=0 -> illegal pulse, illegal pulse, done pulse respectively; no uop_valid for any of the three.
- flush asserted at micro-op 2 of an LMUL8 sequence -> uop_valid=0 the next cycle, no done, next instruction accepted normally. Async reset asserted mid-sequence -> all outputs 0 immediately.
- in_is_reduct=1, vlmul=1 (LMUL2), vs1=5, vd=7, vs2=2 -> 2 micro-ops with vs1=5, vd=7 on both and vs2=2,3; the unaligned vs1/vd are not flagged illegal.

Source files
------------

// File: rtl/riscv_v_pkg.sv
// Shared vector-unit definitions: vtype layout, sizing constants, LMUL
// decode and the sequencer state encoding.
package riscv_v_pkg;

  localparam int RISCV_V_VLEN             = 128;
  localparam int RISCV_V_NUM_ELEMENTS_REG = RISCV_V_VLEN / 8;
  localparam int RISCV_V_MAX_LMUL         = 8;
  localparam int RISCV_V_VL_W = $clog2(RISCV_V_NUM_ELEMENTS_REG * RISCV_V_MAX_LMUL) + 1;

  // vtype bit positions
  localparam int VTYPE_VILL      = 8;
  localparam int VTYPE_VMA       = 7;
  localparam int VTYPE_VTA       = 6;
  localparam int VTYPE_VSEW_LSB  = 3;
  localparam int VTYPE_VLMUL_LSB = 0;

  typedef struct packed {
    logic       vill;
    logic       vma;
    logic       vta;
    logic [2:0] vsew;
    logic [2:0] vlmul;
  } vtype_t;

  typedef enum logic [2:0] {
    LMUL_1    = 3'd0,
    LMUL_2    = 3'd1,
    LMUL_4    = 3'd2,
    LMUL_8    = 3'd3,
    LMUL_RSVD = 3'd4,
    LMUL_F8   = 3'd5,
    LMUL_F4   = 3'd6,
    LMUL_F2   = 3'd7
  } lmul_e;

  typedef enum logic [0:0] {
    SEQ_IDLE  = 1'b0,
    SEQ_ISSUE = 1'b1
  } seq_state_e;

  // log2 of the register group size; fractional and reserved encodings
  // occupy a single register.
  function automatic logic [1:0] lmul_log2(input logic [2:0] vlmul);
    return vlmul[2] ? 2'd0 : vlmul[1:0];
  endfunction

endpackage

// File: rtl/riscv_v_lmul_sequencer_if.sv
// Instruction-in / micro-op-out bundle of the LMUL sequencer.
//   slave  : sequencer side (takes instructions, produces micro-ops)
//   master : issue/execute side (offers instructions, consumes micro-ops)
interface riscv_v_lmul_sequencer_if;
  localparam int VL_W = riscv_v_pkg::RISCV_V_VL_W;

  logic            in_valid;
  logic            in_ready;
  logic [8:0]      in_vtype;
  logic [VL_W-1:0] in_vl;
  logic [VL_W-1:0] in_vstart;
  logic [4:0]      in_vs1;
  logic [4:0]      in_vs2;
  logic [4:0]      in_vd;
  logic            in_is_reduct;
  logic            flush;
  logic            uop_valid;
  logic            uop_ready;
  logic [4:0]      uop_vs1;
  logic [4:0]      uop_vs2;
  logic [4:0]      uop_vd;
  logic [VL_W-1:0] uop_vl;
  logic [VL_W-1:0] uop_vstart;
  logic            uop_first;
  logic            uop_last;
  logic            done;
  logic            illegal;

  modport slave (
    input  in_valid, in_vtype, in_vl, in_vstart, in_vs1, in_vs2, in_vd,
           in_is_reduct, flush, uop_ready,
    output in_ready, uop_valid, uop_vs1, uop_vs2, uop_vd, uop_vl, uop_vstart,
           uop_first, uop_last, done, illegal
  );

  modport master (
    output in_valid, in_vtype, in_vl, in_vstart, in_vs1, in_vs2, in_vd,
           in_is_reduct, flush, uop_ready,
    input  in_ready, uop_valid, uop_vs1, uop_vs2, uop_vd, uop_vl, uop_vstart,
           uop_first, uop_last, done, illegal
  );
endinterface

// File: rtl/riscv_v_uop_bounds.sv
// Per-register element bounds for a grouped vector access (combinational).
//   vl, vstart : instruction-wide element counts
//   epr_log2   : log2(elements per register)
//   nreg_log2  : log2(registers in the group)
//   idx        : register index within the group
//   uop_vl     : clamp(vl - idx*EPR, 0, EPR)
//   uop_vstart : clamp(vstart - idx*EPR, 0, EPR)
//   first      : vstart / EPR
//   last       : min(NREG, ceil(vl/EPR)) - 1 (0 when vl is 0)
module riscv_v_uop_bounds
  import riscv_v_pkg::*;
#(
  parameter int VL_W = RISCV_V_VL_W
) (
  input  logic [VL_W-1:0] vl,
  input  logic [VL_W-1:0] vstart,
  input  logic [2:0]      epr_log2,
  input  logic [1:0]      nreg_log2,
  input  logic [2:0]      idx,
  output logic [VL_W-1:0] uop_vl,
  output logic [VL_W-1:0] uop_vstart,
  output logic [VL_W-1:0] first,
  output logic [VL_W-1:0] last
);

  logic [VL_W-1:0] epr, base;
  logic [VL_W:0]   regs_used, nregs, span;

  function automatic logic [VL_W-1:0] clamp_rem(input logic [VL_W-1:0] x,
                                                 input logic [VL_W-1:0] b,
                                                 input logic [VL_W-1:0] e);
    if (x <= b)         return '0;
    else if (x - b > e) return e;
    else                return x - b;
  endfunction

  assign epr  = VL_W'(1) << epr_log2;
  assign base = VL_W'(idx) << epr_log2;

  assign uop_vl     = clamp_rem(vl, base, epr);
  assign uop_vstart = clamp_rem(vstart, base, epr);
  assign first      = vstart >> epr_log2;

  // one extra bit so the ceil rounding cannot overflow at vl = max
  assign regs_used = ({1'b0, vl} + {1'b0, epr} - 1'b1) >> epr_log2;
  assign nregs     = (VL_W+1)'(1) << nreg_log2;
  assign span      = (regs_used < nregs) ? regs_used : nregs;
  assign last      = (span == '0) ? '0 : VL_W'(span - 1'b1);

endmodule

// File: rtl/riscv_v_lmul_sequencer.sv
// Breaks an LMUL-grouped vector instruction into one micro-op per register.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : instruction offer (in_*), flush, micro-op stream (uop_*),
//              done / illegal completion pulses
module riscv_v_lmul_sequencer
  import riscv_v_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  riscv_v_lmul_sequencer_if.slave   bus
);

  localparam int VL_W = RISCV_V_VL_W;
  localparam logic [0:0] ST_IDLE  = SEQ_IDLE;
  localparam logic [0:0] ST_ISSUE = SEQ_ISSUE;

  logic [0:0]      state;
  logic [VL_W-1:0] vl_q, vstart_q;
  logic [4:0]      vs1_q, vs2_q, vd_q;
  logic            red_q;
  logic [2:0]      epr_log2_q, idx_q, first_q, last_q;
  logic            done_q, illegal_q;

  vtype_t          vt;
  logic            unused_vtype;
  logic            idle, accept, xfer;
  logic            sew_bad, lmul_rsvd, misaligned, illegal_in, empty_in;
  logic [1:0]      nreg_log2_in;
  logic [2:0]      epr_log2_in;
  logic [4:0]      grp_mask;

  logic [VL_W-1:0] b_vl, b_vstart, b_uop_vl, b_uop_vstart, b_first, b_last;
  logic [2:0]      b_epr, b_idx;

  assign vt           = vtype_t'(bus.in_vtype);
  assign unused_vtype = vt.vma ^ vt.vta;

  assign idle   = (state == ST_IDLE);
  assign accept = bus.in_valid & idle;
  assign xfer   = ~idle & bus.uop_ready;

  assign sew_bad      = vt.vsew > 3'd4;
  assign lmul_rsvd    = lmul_e'(vt.vlmul) == LMUL_RSVD;
  assign nreg_log2_in = lmul_log2(vt.vlmul);
  assign grp_mask     = 5'((5'd1 << nreg_log2_in) - 5'd1);
  // reductions read vs1 and write vd as single registers, so only vs2 is grouped
  assign misaligned   = (|(bus.in_vs2 & grp_mask)) |
                        (~bus.in_is_reduct & ((|(bus.in_vs1 & grp_mask)) |
                                              (|(bus.in_vd  & grp_mask))));
  assign illegal_in   = vt.vill | sew_bad | lmul_rsvd | misaligned;
  assign epr_log2_in  = sew_bad ? 3'd0 : 3'd4 - vt.vsew;

  // One bounds unit: while idle it sizes the offered instruction, while
  // issuing it produces the element window of the current register.
  assign b_vl     = idle ? bus.in_vl     : vl_q;
  assign b_vstart = idle ? bus.in_vstart : vstart_q;
  assign b_epr    = idle ? epr_log2_in   : epr_log2_q;
  assign b_idx    = idle ? 3'd0          : idx_q;

  riscv_v_uop_bounds #(.VL_W(VL_W)) u_bounds (
    .vl         (b_vl),
    .vstart     (b_vstart),
    .epr_log2   (b_epr),
    .nreg_log2  (nreg_log2_in),
    .idx        (b_idx),
    .uop_vl     (b_uop_vl),
    .uop_vstart (b_uop_vstart),
    .first      (b_first),
    .last       (b_last)
  );

  // first > last happens when vstart lies beyond the group (vl > VLMAX);
  // nothing would issue, so it completes like an empty instruction.
  assign empty_in = (bus.in_vl == '0) | (bus.in_vstart >= bus.in_vl) |
                    (b_first > b_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      vl_q       <= '0;
      vstart_q   <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      vd_q       <= '0;
      red_q      <= 1'b0;
      epr_log2_q <= '0;
      idx_q      <= '0;
      first_q    <= '0;
      last_q     <= '0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      done_q    <= accept & ~bus.flush & ~illegal_in & empty_in;
      illegal_q <= accept & ~bus.flush & illegal_in;
      if (bus.flush) begin
        state <= ST_IDLE;
      end else if (accept & ~illegal_in & ~empty_in) begin
        state      <= ST_ISSUE;
        vl_q       <= bus.in_vl;
        vstart_q   <= bus.in_vstart;
        vs1_q      <= bus.in_vs1;
        vs2_q      <= bus.in_vs2;
        vd_q       <= bus.in_vd;
        red_q      <= bus.in_is_reduct;
        epr_log2_q <= epr_log2_in;
        idx_q      <= b_first[2:0];
        first_q    <= b_first[2:0];
        last_q     <= b_last[2:0];
      end else if (xfer) begin
        if (idx_q == last_q) state <= ST_IDLE;
        else                 idx_q <= idx_q + 3'd1;
      end
    end
  end

  // Outputs are gated by valid so an idle sequencer presents all zeros.
  assign bus.in_ready   = idle;
  assign bus.uop_valid  = ~idle;
  assign bus.uop_vs2    = idle ? '0 : vs2_q + 5'(idx_q);
  assign bus.uop_vs1    = idle ? '0 : (red_q ? vs1_q : vs1_q + 5'(idx_q));
  assign bus.uop_vd     = idle ? '0 : (red_q ? vd_q  : vd_q  + 5'(idx_q));
  assign bus.uop_vl     = idle ? '0 : b_uop_vl;
  assign bus.uop_vstart = idle ? '0 : b_uop_vstart;
  assign bus.uop_first  = ~idle & (idx_q == first_q);
  assign bus.uop_last   = ~idle & (idx_q == last_q);
  assign bus.done       = done_q | (xfer & (idx_q == last_q) & ~bus.flush);
  assign bus.illegal    = illegal_q;

endmodule
